ram_partition_ctrl: RTL and testbench

RAM_PARTITION_CTRL -- requirements
Module: ram_partition_ctrl

---
 rtl/ram_partition_ctrl_pkg.sv | 21 ++
 rtl/ram_partition_ctrl.sv | 144 ++++++++++++++
 tb/tb_ram_partition_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_partition_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ram_partition_ctrl_pkg
// Description : Shared RAM configuration: partition defaults and the
//               resize controller state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ram_partition_ctrl_pkg;

    localparam int RAM_PARTS     = 8;
    localparam int RAM_PARTS_LOG = 3;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DRAIN      = 2'd1,
        APPLY      = 2'd2,
        WAIT_READY = 2'd3
    } partState_t;

endpackage
`default_nettype wire

// File: rtl/ram_partition_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ram_partition_ctrl
// Description : Resizes the active RAM partition set: quiesces writes, updates
//               the gating mask, then waits for the RAM to report ready.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_partition_ctrl
    import ram_partition_ctrl_pkg::*;
#(
    parameter int NUM_PARTS     = RAM_PARTS,
    parameter int NUM_PARTS_LOG = RAM_PARTS_LOG,
    parameter int DRAIN_CYCLES  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     reqValid_i,
    input  logic [NUM_PARTS_LOG:0]   reqParts_i,
    output logic                     reqReady_o,
    input  logic                     ramReady_i,
    output logic [NUM_PARTS-1:0]     partitionGated_o,
    output logic                     wrBlock_o,
    output logic [NUM_PARTS_LOG:0]   activeParts_o,
    output logic                     done_o,
    output logic                     errInvalid_o
);

    localparam int c_partW = NUM_PARTS_LOG + 1;
    localparam int c_cntW  = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    localparam logic [c_partW-1:0] c_maxParts  = c_partW'(NUM_PARTS);
    localparam logic [c_cntW-1:0]  c_drainLoad = c_cntW'(DRAIN_CYCLES - 1);
    localparam logic [c_cntW-1:0]  c_cntOne    = c_cntW'(1);

    partState_t                 r_state;
    partState_t                 w_nextState;
    logic [c_cntW-1:0]          r_drainCnt;
    logic [c_partW-1:0]         r_target;
    logic [NUM_PARTS-1:0]       r_gated;
    logic [c_partW-1:0]         r_active;
    logic                       r_done;
    logic                       r_err;
    logic                       w_illegal;
    logic                       w_noChange;
    logic [NUM_PARTS-1:0]       w_newMask;

    assign w_illegal  = (reqParts_i == '0) || (reqParts_i > c_maxParts);
    assign w_noChange = (reqParts_i == r_active);

    // Partitions at or above the target count are gated; target >= 1 keeps 0 live.
    for (genvar p = 0; p < NUM_PARTS; p++) begin : g_mask
        assign w_newMask[p] = (c_partW'(p) >= r_target);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= WAIT_READY;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (reqValid_i && !w_illegal && !w_noChange) begin
                    w_nextState = DRAIN;
                end
            end
            DRAIN: begin
                if (r_drainCnt == '0) begin
                    w_nextState = APPLY;
                end
            end
            APPLY: begin
                w_nextState = WAIT_READY;
            end
            WAIT_READY: begin
                if (ramReady_i) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_comb begin
        reqReady_o = (r_state == IDLE);
        wrBlock_o  = (r_state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_drainCnt <= '0;
            r_target   <= c_maxParts;
            r_gated    <= '0;
            r_active   <= c_maxParts;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (reqValid_i) begin
                        if (w_illegal) begin
                            r_err <= 1'b1;
                        end else if (w_noChange) begin
                            r_done <= 1'b1;
                        end else begin
                            r_target   <= reqParts_i;
                            r_drainCnt <= c_drainLoad;
                        end
                    end
                end
                DRAIN: begin
                    if (r_drainCnt == '0) begin
                        r_gated  <= w_newMask;
                        r_active <= r_target;
                    end else begin
                        r_drainCnt <= r_drainCnt - c_cntOne;
                    end
                end
                WAIT_READY: begin
                    if (ramReady_i) begin
                        r_done <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign partitionGated_o = r_gated;
    assign activeParts_o    = r_active;
    assign done_o           = r_done;
    assign errInvalid_o     = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ram_partition_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_partition_ctrl
// Description : Self-checking bench: timeline model of a resize plus directed
//               scenarios and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_partition_ctrl;

    localparam int NP  = 8;
    localparam int NPL = 3;
    localparam int DC  = 4;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           reqValid = 1'b0;
    logic [NPL:0]   reqParts = '0;
    logic           ramReady = 1'b0;
    logic           reqReady;
    logic [NP-1:0]  gated;
    logic           wrBlock;
    logic [NPL:0]   active;
    logic           done;
    logic           errInv;

    int errors = 0;
    int checks = 0;

    ram_partition_ctrl #(
        .NUM_PARTS(NP),
        .NUM_PARTS_LOG(NPL),
        .DRAIN_CYCLES(DC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .reqValid_i(reqValid),
        .reqParts_i(reqParts),
        .reqReady_o(reqReady),
        .ramReady_i(ramReady),
        .partitionGated_o(gated),
        .wrBlock_o(wrBlock),
        .activeParts_o(active),
        .done_o(done),
        .errInvalid_o(errInv)
    );

    always #5 clk = ~clk;

    // Timeline model: a resize is "busy" from accept; the mask lands after
    // DC drain cycles, and the busy period ends once ready is seen after APPLY.
    bit     mValid = 0;
    bit     mBusy;
    int     mElapsed;
    int     mTarget;
    int     mActive;
    int     mMask;
    bit     mDone;
    bit     mErr;

    function automatic int maskFor(int n);
        return ((1 << NP) - 1) & ~((1 << n) - 1);
    endfunction

    always @(posedge clk) begin
        mDone = 0;
        mErr  = 0;
        if (reset) begin
            mValid   = 1;
            mBusy    = 1;
            mElapsed = DC + 1;
            mMask    = 0;
            mActive  = NP;
            mTarget  = NP;
        end else if (mValid) begin
            if (!mBusy) begin
                if (reqValid) begin
                    if (reqParts == 0 || int'(reqParts) > NP) mErr = 1;
                    else if (int'(reqParts) == mActive) mDone = 1;
                    else begin
                        mBusy    = 1;
                        mElapsed = 0;
                        mTarget  = int'(reqParts);
                    end
                end
            end else begin
                if (mElapsed == DC - 1) begin
                    mMask   = maskFor(mTarget);
                    mActive = mTarget;
                end
                if (mElapsed >= DC + 1 && ramReady) begin
                    mBusy = 0;
                    mDone = 1;
                end
                mElapsed++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mValid) begin
            check("reqReady", 32'(reqReady), 32'(!mBusy));
            check("wrBlock",  32'(wrBlock),  32'(mBusy));
            check("mask",     32'(gated),    32'(mMask));
            check("active",   32'(active),   32'(mActive));
            check("done",     32'(done),     32'(mDone));
            check("errInv",   32'(errInv),   32'(mErr));
        end
    end

    task automatic cycle();
        @(negedge clk);
    endtask

    task automatic waitDone(input int maxCycles, output int at);
        at = -1;
        for (int i = 1; i <= maxCycles; i++) begin
            cycle();
            if (done === 1'b1) begin
                at = i;
                break;
            end
        end
    endtask

    initial begin
        int at;
        int cnt;
        int doneAt;

        // Reset, ready arrives three cycles after release
        reset = 1'b1; ramReady = 1'b0;
        cycle(); cycle();
        check("rst_mask", 32'(gated), 32'h00);
        check("rst_active", 32'(active), 32'd8);
        check("rst_wrBlock", 32'(wrBlock), 32'd1);
        reset = 1'b0;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            cnt += int'(done);
            check("rst_hold_ready", 32'(reqReady), 32'd0);
        end
        ramReady = 1'b1;
        waitDone(5, at);
        check("rst_done_at", 32'(at), 32'd1);
        cycle();
        check("rst_done_once", 32'(cnt + int'(done)), 32'd0);
        check("rst_reqReady", 32'(reqReady), 32'd1);
        check("rst_mask_after", 32'(gated), 32'h00);

        // Same count as current: immediate done, no write block
        reqValid = 1'b1; reqParts = 4'd8;
        cycle();
        reqValid = 1'b0;
        check("same_done", 32'(done), 32'd1);
        cnt = int'(wrBlock);
        for (int i = 0; i < 4; i++) begin cycle(); cnt += int'(wrBlock); end
        check("same_noblock", 32'(cnt), 32'd0);

        // Resize to 3 with ready high
        reqValid = 1'b1; reqParts = 4'd3;
        cnt = 0; doneAt = -1;
        for (int i = 1; i <= 10; i++) begin
            cycle();
            if (i == 1) reqValid = 1'b0;
            cnt += int'(wrBlock);
            if (done === 1'b1 && doneAt < 0) doneAt = i;
        end
        check("r3_block_cycles", 32'(cnt), 32'd6);
        check("r3_done_at", 32'(doneAt), 32'd7);
        check("r3_mask", 32'(gated), 32'hF8);
        check("r3_active", 32'(active), 32'd3);

        // Illegal requests 0 then 9
        cnt = 0;
        reqValid = 1'b1; reqParts = 4'd0;
        cycle(); cnt += int'(errInv);
        reqParts = 4'd9;
        cycle(); cnt += int'(errInv);
        reqValid = 1'b0;
        cycle(); cnt += int'(errInv);
        check("err_pulses", 32'(cnt), 32'd2);
        check("err_mask", 32'(gated), 32'hF8);
        check("err_idle", 32'(reqReady), 32'd1);

        // Resize to 2 with RAM not ready; later request 5 ignored
        ramReady = 1'b0;
        reqValid = 1'b1; reqParts = 4'd2;
        cycle();
        reqValid = 1'b0;
        for (int i = 0; i < 5; i++) cycle();
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) begin reqValid = 1'b1; reqParts = 4'd5; end
            else reqValid = 1'b0;
            cycle();
            cnt += int'(wrBlock) + 2 * int'(done);
        end
        reqValid = 1'b0;
        check("r2_wait_hold", 32'(cnt), 32'd10);
        ramReady = 1'b1;
        waitDone(5, at);
        check("r2_done_at", 32'(at), 32'd1);
        check("r2_mask", 32'(gated), 32'hFC);
        check("r2_active", 32'(active), 32'd2);

        // Reset in the 2nd drain cycle of a request for 1
        reqValid = 1'b1; reqParts = 4'd1;
        cycle();
        reqValid = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("rstd_mask", 32'(gated), 32'h00);
        check("rstd_active", 32'(active), 32'd8);
        check("rstd_wait", 32'(wrBlock), 32'd1);
        waitDone(5, at);
        check("rstd_done_at", 32'(at), 32'd1);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            reset    = ($urandom_range(0, 199) == 0);
            reqValid = ($urandom_range(0, 2) == 0);
            reqParts = 4'($urandom_range(0, 10));
            ramReady = ($urandom_range(0, 3) != 0);
            cycle();
        end
        reset = 1'b0; reqValid = 1'b0;
        cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
